// File: rtl/serial_parity_checker_if.sv
// Frame-level signal bundle for serial_parity_checker: serial input side plus
// the word-level result side. The master drives the serial line, the slave checks it.
interface serial_parity_checker_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              odd_mode;
  logic              din_valid;
  logic              din;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data_out;
  logic              err;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output start, odd_mode, din_valid, din,
    input  busy, done, data_out, err, err_cnt
  );

  modport slave (
    input  start, odd_mode, din_valid, din,
    output busy, done, data_out, err, err_cnt
  );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial parity checker: deserialises DATA_W data bits (LSB first) plus a parity bit.
// Optional saturating error counter enabled by defining SERIAL_PARITY_ERR_CNT_EN.
module serial_parity_checker #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_parity_checker_if.slave  bus
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t            state_reg;
  logic              mode_odd_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [IDX_W-1:0]  idx_reg;
  logic              parity_reg;
  logic              done_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              err_reg;

  logic take_data;
  logic take_par;
  logic frame_err;

  // start always wins, so a bit arriving alongside start is never accepted
  assign take_data = (state_reg == DATA) && !bus.start && bus.din_valid;
  assign take_par  = (state_reg == PAR)  && !bus.start && bus.din_valid;

  // Total ones odd is an error in even mode; total ones even is an error in odd mode
  assign frame_err = parity_reg ^ bus.din ^ mode_odd_reg;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
      assign shift_next[gi] = (take_data && (idx_reg == IDX_W'(gi))) ? bus.din : shift_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      mode_odd_reg <= 1'b0;
      shift_reg    <= '0;
      idx_reg      <= '0;
      parity_reg   <= 1'b0;
      done_reg     <= 1'b0;
      data_out_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.start) begin
        state_reg    <= DATA;
        mode_odd_reg <= bus.odd_mode;
        shift_reg    <= '0;
        idx_reg      <= '0;
        parity_reg   <= 1'b0;
      end else begin
        case (state_reg)
          DATA: begin
            if (take_data) begin
              shift_reg  <= shift_next;
              parity_reg <= parity_reg ^ bus.din;
              if (idx_reg == LAST_IDX) begin
                idx_reg   <= '0;
                state_reg <= PAR;
              end else begin
                idx_reg <= idx_reg + IDX_W'(1);
              end
            end
          end
          PAR: begin
            if (take_par) begin
              done_reg     <= 1'b1;
              data_out_reg <= shift_reg;
              err_reg      <= frame_err;
              state_reg    <= IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef SERIAL_PARITY_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_reg <= '0;
    end else if (take_par && frame_err && (err_cnt_reg != CNT_MAX)) begin
      err_cnt_reg <= err_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.err_cnt = err_cnt_reg;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = done_reg;
  assign bus.data_out = data_out_reg;
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: directed frames with literal results plus a
// random phase checked every cycle against a frame-level queue model.
module tb_serial_parity_checker;

  localparam int DATA_W = 4;
`ifdef SERIAL_PARITY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_s = 1'b0;
  logic odd_s = 1'b0;
  logic dv_s = 1'b0;
  logic din_s = 1'b0;

  always #5 clk = ~clk;

  serial_parity_checker_if #(.DATA_W(DATA_W), .CNT_W(8)) if8 ();
  serial_parity_checker_if #(.DATA_W(DATA_W), .CNT_W(2)) if2 ();

  assign if8.start = start_s;
  assign if8.odd_mode = odd_s;
  assign if8.din_valid = dv_s;
  assign if8.din = din_s;
  assign if2.start = start_s;
  assign if2.odd_mode = odd_s;
  assign if2.din_valid = dv_s;
  assign if2.din = din_s;

  serial_parity_checker #(.DATA_W(DATA_W), .CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
  serial_parity_checker #(.DATA_W(DATA_W), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  int vectors = 0;
  int miscompares = 0;
  int done_count = 0;
  bit ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: collect accepted bits in a queue, judge a frame once complete
  bit active = 1'b0;
  bit mode = 1'b0;
  bit q[$];
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  int m_data = 0;
  int m_cnt8 = 0;
  int m_cnt2 = 0;

  always @(posedge clk) begin
    int ones;
    m_done = 1'b0;
    if (reset) begin
      active = 1'b0;
      q.delete();
      m_data = 0;
      m_err = 1'b0;
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (start_s) begin
      active = 1'b1;
      mode = odd_s;
      q.delete();
    end else if (active && dv_s) begin
      q.push_back(din_s);
      if (q.size() == DATA_W + 1) begin
        ones = 0;
        m_data = 0;
        for (int i = 0; i <= DATA_W; i++) begin
          ones += int'(q[i]);
          if (i < DATA_W) m_data += int'(q[i]) << i;
        end
        m_err = ((ones % 2) == 1) ^ mode;
        m_done = 1'b1;
        if (m_err) begin
          m_cnt8 = (m_cnt8 == 255) ? 255 : m_cnt8 + 1;
          m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
        end
        active = 1'b0;
        q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (ready) begin
      if (if8.done) done_count++;
      check("busy", int'(if8.busy), int'(active));
      check("done", int'(if8.done), int'(m_done));
      check("data_out", int'(if8.data_out), m_data);
      check("err", int'(if8.err), int'(m_err));
      check("err_cnt8", int'(if8.err_cnt), CNT_EN ? m_cnt8 : 0);
      check("err_cnt2", int'(if2.err_cnt), CNT_EN ? m_cnt2 : 0);
      check("done2", int'(if2.done), int'(m_done));
    end
  end

  task automatic send(input bit b, input int gap);
    repeat (gap) @(negedge clk);
    dv_s = 1'b1;
    din_s = b;
    @(negedge clk);
    dv_s = 1'b0;
  endtask

  task automatic frame(input bit odd, input logic [3:0] data, input bit par, input int gap);
    start_s = 1'b1;
    odd_s = odd;
    dv_s = 1'b0;
    @(negedge clk);
    start_s = 1'b0;
    for (int i = 0; i < DATA_W; i++) send(data[i], gap);
    send(par, gap);
  endtask

  task automatic result(input string name, input int data, input int e, input int c8, input int c2);
    check({name, ".done"}, int'(if8.done), 1);
    check({name, ".data"}, int'(if8.data_out), data);
    check({name, ".err"}, int'(if8.err), e);
    check({name, ".cnt8"}, int'(if8.err_cnt), CNT_EN ? c8 : 0);
    check({name, ".cnt2"}, int'(if2.err_cnt), CNT_EN ? c2 : 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    start_s = 1'b0;
    dv_s = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle_outputs(input string name);
    check({name, ".busy"}, int'(if8.busy), 0);
    check({name, ".done"}, int'(if8.done), 0);
    check({name, ".data"}, int'(if8.data_out), 0);
    check({name, ".err"}, int'(if8.err), 0);
    check({name, ".cnt8"}, int'(if8.err_cnt), 0);
  endtask

  initial begin
    int dc;
    repeat (3) @(negedge clk);
    idle_outputs("reset");
    reset = 1'b0;
    ready = 1'b1;

    frame(1'b0, 4'b1101, 1'b1, 0);
    result("even_ok", 13, 0, 0, 0);
    @(negedge clk);
    check("done_pulse", int'(if8.done), 0);

    frame(1'b0, 4'b1101, 1'b0, 0);
    result("even_bad", 13, 1, 1, 1);
    frame(1'b1, 4'b1101, 1'b0, 0);
    result("odd_ok", 13, 0, 1, 1);

    // Next frame starts in the cycle done is high
    dc = done_count + 1;
    frame(1'b0, 4'b1101, 1'b1, 3);
    result("gaps", 13, 0, 1, 1);
    @(negedge clk);
    check("gaps.one_done", done_count, dc + 1);

    dc = done_count;
    start_s = 1'b1; odd_s = 1'b0;
    @(negedge clk);
    start_s = 1'b0;
    send(1'b1, 0);
    send(1'b1, 0);
    frame(1'b1, 4'b0110, 1'b1, 0);
    result("abort", 6, 0, 1, 1);
    @(negedge clk);
    check("abort.one_done", done_count, dc + 1);

    pulse_reset();
    for (int k = 1; k <= 5; k++) begin
      frame(1'b0, 4'b1101, 1'b0, 0);
      result("sat", 13, 1, k, (k > 3) ? 3 : k);
    end

    start_s = 1'b1; odd_s = 1'b0;
    @(negedge clk);
    start_s = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 0);
    pulse_reset();
    idle_outputs("mid_reset");
    frame(1'b0, 4'b1101, 1'b1, 0);
    result("after_reset", 13, 0, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      start_s = ($urandom_range(0, 14) == 0);
      odd_s = 1'($urandom);
      dv_s = ($urandom_range(0, 2) != 0);
      din_s = 1'($urandom);
      @(negedge clk);
    end
    reset = 1'b0; start_s = 1'b0; dv_s = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
